// File: rtl/tabla_pkg.sv
// Shared encodings for the PE-array slot logic: relay FSM states and memory namespace codes.
package tabla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } relay_state_e;

  localparam int NS_INST   = 0;
  localparam int NS_DATA   = 1;
  localparam int NS_WEIGHT = 2;
  localparam int NS_META   = 3;

endpackage

// File: rtl/relay_fifo.sv
// Circular relay buffer with registered output stage; an empty FIFO forwards the
// incoming word straight to the output register so relay latency stays at one cycle.
module relay_fifo #(
  parameter int dataLen      = 16,
  parameter int fifoDepthLog = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [dataLen-1:0] din_i,
  input  logic               pop_en_i,
  output logic [dataLen-1:0] dout_o,
  output logic               dout_v_o,
  output logic               empty_o,
  output logic               ovf_o
);

  localparam int DEPTH = 1 << fifoDepthLog;
  localparam int CW    = fifoDepthLog + 1;

  logic [dataLen-1:0]      mem_q [DEPTH];
  logic [fifoDepthLog-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [dataLen-1:0]      dout_q;
  logic                    dout_v_q;
  logic                    full, pop, wr, rd;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop     = pop_en_i && (!empty_o || push_i);
  // A pushed word is stored unless it bypasses an empty FIFO or hits a full one with no pop.
  assign wr      = push_i && (pop ? !empty_o : !full);
  assign rd      = pop && !empty_o;
  assign ovf_o   = push_i && full && !pop;
  assign cnt_d   = cnt_q + CW'(wr) - CW'(rd);

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dout_v_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dout_v_q <= pop;
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (pop) dout_q <= empty_o ? din_i : mem_q[rd_ptr_q];
    end
  end

  assign dout_o   = dout_q;
  assign dout_v_o = dout_v_q;

endmodule

// File: rtl/pe_relay.sv
// Empty-PE slot: relays PE/PU neighbour chains and emulates instruction-loop timing.
// Optional PE_RELAY_STATUS_EN adds sticky overflow flags and meta-namespace status readback.
module pe_relay
  import tabla_pkg::*;
#(
  parameter int peId              = 0,
  parameter int puId              = 0,
  parameter int dataLen           = 16,
  parameter int memDataLen        = 16,
  parameter int logMemNamespaces  = 2,
  parameter int logNumPeMemColumn = 2,
  parameter int peBusIndexLen     = 3,
  parameter int gbBusIndexLen     = 3,
  parameter int fifoDepthLog      = 2,
  parameter int instCntLen        = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mem_wrt_valid,
  input  logic                         mem_weight_rd_valid,
  input  logic [logNumPeMemColumn-1:0] peId_mem_in,
  input  logic [logMemNamespaces-1:0]  mem_data_type,
  input  logic [memDataLen-1:0]        mem_data_input,
  output logic [memDataLen-1:0]        mem_data_output,
  output logic                         inst_eol,
  input  logic [dataLen-1:0]           pe_neigh_data_in,
  input  logic                         pe_neigh_data_in_v,
  input  logic [dataLen-1:0]           pu_neigh_data_in,
  input  logic                         pu_neigh_data_in_v,
  input  logic [dataLen-1:0]           pe_bus_data_in,
  input  logic                         pe_bus_data_in_v,
  input  logic [dataLen-1:0]           gb_bus_data_in,
  input  logic                         gb_bus_data_in_v,
  output logic [dataLen-1:0]           pe_neigh_data_out,
  output logic                         pe_neigh_data_out_v,
  output logic [dataLen-1:0]           pu_neigh_data_out,
  output logic                         pu_neigh_data_out_v,
  output logic [dataLen-1:0]           pe_bus_data_out,
  output logic [peBusIndexLen-1:0]     pe_bus_data_out_v,
  output logic [dataLen-1:0]           gb_bus_data_out,
  output logic [gbBusIndexLen-1:0]     gb_bus_data_out_v,
  input  logic                         pe_bus_contention,
  input  logic                         gb_bus_contention
);

  localparam logic [logNumPeMemColumn-1:0] PE_COL = logNumPeMemColumn'(peId);

  relay_state_e            state_q, state_d;
  logic [instCntLen-1:0]   inst_cnt_q, loop_cnt_q, loop_cnt_d;
  logic                    inst_eol_q, inst_eol_d;
  logic                    pe_match, inst_wr, active;
  logic                    pe_empty, pu_empty, pe_ovf, pu_ovf;

  assign pe_match = (peId_mem_in == PE_COL);
  assign inst_wr  = mem_wrt_valid && pe_match &&
                    (mem_data_type == logMemNamespaces'(NS_INST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) inst_cnt_q <= '0;
    else if (inst_wr && inst_cnt_q != '1) inst_cnt_q <= inst_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      loop_cnt_q <= '0;
      inst_eol_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      loop_cnt_q <= loop_cnt_d;
      inst_eol_q <= inst_eol_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    loop_cnt_d = loop_cnt_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_RUN;
        loop_cnt_d = inst_cnt_q;
      end
      ST_RUN: begin
        if (loop_cnt_q == '0) state_d = ST_DRAIN;
        else loop_cnt_d = loop_cnt_q - 1'b1;
      end
      ST_DRAIN: if (pe_empty && pu_empty) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // EOL is registered, so it is raised one cycle ahead of the RUN cycle where loop_cnt hits 0.
  always_comb begin
    active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    inst_eol_d = ((state_q == ST_IDLE) && start && (inst_cnt_q == '0)) ||
                 ((state_q == ST_RUN) && (loop_cnt_q == instCntLen'(1)));
  end

  assign inst_eol = inst_eol_q;

  relay_fifo #(.dataLen(dataLen), .fifoDepthLog(fifoDepthLog)) u_pe_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (pe_neigh_data_in_v),
    .din_i    (pe_neigh_data_in),
    .pop_en_i (active),
    .dout_o   (pe_neigh_data_out),
    .dout_v_o (pe_neigh_data_out_v),
    .empty_o  (pe_empty),
    .ovf_o    (pe_ovf)
  );

  relay_fifo #(.dataLen(dataLen), .fifoDepthLog(fifoDepthLog)) u_pu_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (pu_neigh_data_in_v),
    .din_i    (pu_neigh_data_in),
    .pop_en_i (active),
    .dout_o   (pu_neigh_data_out),
    .dout_v_o (pu_neigh_data_out_v),
    .empty_o  (pu_empty),
    .ovf_o    (pu_ovf)
  );

  assign pe_bus_data_out   = '0;
  assign pe_bus_data_out_v = '0;
  assign gb_bus_data_out   = '0;
  assign gb_bus_data_out_v = '0;

`ifdef PE_RELAY_STATUS_EN
  logic                  ovf_pe_q, ovf_pu_q, meta_rd;
  logic [memDataLen-1:0] mem_rd_q;

  assign meta_rd = mem_weight_rd_valid && pe_match &&
                   (mem_data_type == logMemNamespaces'(NS_META));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_pe_q <= 1'b0;
      ovf_pu_q <= 1'b0;
      mem_rd_q <= '0;
    end else begin
      if (pe_ovf) ovf_pe_q <= 1'b1;
      if (pu_ovf) ovf_pu_q <= 1'b1;
      mem_rd_q <= meta_rd ? memDataLen'({ovf_pu_q, ovf_pe_q, inst_cnt_q}) : '0;
    end
  end

  assign mem_data_output = mem_rd_q;

  logic unused_ign;
  assign unused_ign = ^{mem_data_input, pe_bus_data_in, pe_bus_data_in_v, gb_bus_data_in,
                        gb_bus_data_in_v, pe_bus_contention, gb_bus_contention};
`else
  assign mem_data_output = '0;

  logic unused_ign;
  assign unused_ign = ^{mem_data_input, pe_bus_data_in, pe_bus_data_in_v, gb_bus_data_in,
                        gb_bus_data_in_v, pe_bus_contention, gb_bus_contention,
                        mem_weight_rd_valid, pe_ovf, pu_ovf};
`endif

endmodule
